crop_xwindow: RTL and testbench
===============================

Name: crop_xwindow

Overview:
- Downstream consumer of the per-frame horizontal-start result (XSTART) produced by the crop-start finder.
- Re-scans the same 640x480 pixel stream (iDVAL/iDATA) and forwards only pixels inside a fixed-size window:
  - columns [xs, xs+CROP_W)
  - rows [Y_START, Y_START+CROP_H)
- xs is XSTART, latched once per frame.
- Emits window-relative coordinates plus start-of-frame and end-of-frame strobes for the capture/store stage.

Parameters:
- DW, 10: pixel data width
- H_ACT, 640: active pixels per line
- V_ACT, 480: active lines per frame
- CROP_W, 320: output window width in pixels
- Y_START, 0: first output row
- CROP_H, 480: output window height in lines
- DEF_XSTART, 160: xs used when iXSTART==0, i.e. the finder produced no result

Ports:
- iCLK  in  1  single clock; all logic rises on iCLK
- iRST  in  1  reset, synchronous, active-high
- iDVAL  in  1  input pixel valid; one pixel per cycle when high, stalls when low
- iDATA  in  DW  input pixel
- iXSTART  in  16  horizontal start from the crop-start finder; static between frames
- oDVAL  out  1  output pixel valid
- oDATA  out  DW  cropped pixel
- oX  out  16  column within window, 0..CROP_W-1
- oY  out  16  row within window, 0..CROP_H-1
- oSOF  out  1  one-cycle pulse with the first output pixel of a frame
- oEOF  out  1  one-cycle pulse with the last output pixel of a frame
- oCLAMP  out  1  high for a frame whose iXSTART was clamped; updated at each latch

Behaviour:
- Reset is synchronous, active-high: iRST high at a rising edge clears every register.
  - oDVAL, oSOF, oEOF, oCLAMP = 0; oDATA, oX, oY = 0.
  - Input counters X_Cont, Y_Cont = 0; state = S_IDLE; xs = DEF_XSTART.
- Reset mid-frame aborts the frame. The next iDVAL pixel is treated as pixel (0,0).
- Counters:
  - X_Cont and Y_Cont advance only on cycles with iDVAL=1.
  - X_Cont wraps at H_ACT-1 and increments Y_Cont at that wrap.
  - Y_Cont wraps at V_ACT-1 back to 0.
  - The pixel at X_Cont=H_ACT-1, Y_Cont=V_ACT-1 is the frame end.
- FSM:
  - S_IDLE: waiting for first pixel of a frame. On iDVAL=1:
    - latch xs
    - go to S_RUN
    - this pixel is processed as (0,0)
  - S_RUN: streaming. On the frame-end pixel, return to S_IDLE.
- xs latch rule, applied in the same cycle as the first pixel:
  - if iXSTART==0: xs = DEF_XSTART
  - else if iXSTART > H_ACT-CROP_W: xs = H_ACT-CROP_W and oCLAMP = 1
  - else: xs = iXSTART and oCLAMP = 0
- xs is frozen for the whole frame; iXSTART changes mid-frame are ignored.
- In-window test uses the counter values of the current input pixel:
  - xs <= X_Cont < xs+CROP_W
  - Y_START <= Y_Cont < Y_START+CROP_H
  - Comparisons are 16-bit unsigned. CROP_W+H_ACT must fit in 16 bits.
- Output, latency exactly 1 cycle:
  - oDVAL(t+1) = iDVAL(t) & in_window(t)
  - oDATA = iDATA, oX = X_Cont-xs, oY = Y_Cont-Y_START
  - oDATA/oX/oY hold their last values when oDVAL=0
- oSOF = oDVAL & oX==0 & oY==0.
- oEOF = oDVAL & oX==CROP_W-1 & oY==CROP_H-1.
- Per full frame, exactly CROP_W*CROP_H output beats with no gaps other than those caused by iDVAL stalls.
- iDVAL low mid-line: no counter change, oDVAL=0, state held.

Decomposition:
- Shared package (crop_pkg):
  - H_ACT/V_ACT frame constants
  - coordinate width (16)
  - FSM state enum {S_IDLE, S_RUN}
  - the same constants used by the crop-start finder
- One natural sub-module: frame_pos_counter.
  - Holds the iDVAL-gated X/Y counters, wrap logic and frame-end flag.
  - Reusable by the finder and any later stage.
- Window compare, xs latch/clamp and output register stay in crop_xwindow.

Test Plan:
- Reset state: iRST=1 for 3 cycles with iDVAL=1 -> all outputs 0, no oDVAL. Release, drive a full frame with iXSTART=200 -> first oDVAL one cycle after input pixel (200,0).
  - oSOF on that beat; 320*480=153600 beats; oEOF on the beat for input (519,479).
- Default xs: iXSTART=0 -> window starts at input column 160; oCLAMP=0.
- Clamp: iXSTART=500 -> xs=320; oCLAMP=1. Last beat of each line comes from input column 639 with oX=319.
- Stalls: random 30% iDVAL=0 over a frame with iXSTART=100 -> same 153600 beats. Data equals the input pixels at columns 100..419 in order, with the same oX/oY sequence as the no-stall run.
- Mid-frame iXSTART change: iXSTART switches 100->300 at input line 200 -> frame N still uses xs=100; frame N+1 uses xs=300.
- Reset mid-operation: assert iRST at input (50,240) for 1 cycle, then resume the stream -> the next pixel is treated as (0,0), state S_IDLE->S_RUN, xs re-latched, no oEOF from the aborted frame.

Source files
------------

// File: rtl/crop_xwindow_pkg.sv
// Shared frame constants, coordinate type and FSM state encoding for the
// crop-start finder and the crop window stages.
package crop_pkg;
  localparam int FRAME_W      = 640;
  localparam int FRAME_H      = 480;
  localparam int COORD_W      = 16;
  localparam int DEF_CROP_W   = 320;
  localparam int DEF_XSTART_C = 160;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/crop_xwindow_frame_pos_counter.sv
// Valid-gated raster position counter: X/Y of the current input pixel plus
// a combinational flag marking the last pixel of the frame.
module frame_pos_counter
  import crop_pkg::*;
#(
  parameter int H_ACT = FRAME_W,
  parameter int V_ACT = FRAME_H
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   dval_i,
  output coord_t x_o,
  output coord_t y_o,
  output logic   frame_end_o
);

  coord_t x_q, x_d;
  coord_t y_q, y_d;
  logic   x_last_s, y_last_s;

  always_comb begin
    x_last_s    = (x_q == coord_t'(H_ACT - 1));
    y_last_s    = (y_q == coord_t'(V_ACT - 1));
    frame_end_o = dval_i & x_last_s & y_last_s;
    x_d         = x_q;
    y_d         = y_q;
    if (dval_i) begin
      if (x_last_s) begin
        x_d = '0;
        y_d = y_last_s ? '0 : (y_q + 16'd1);
      end else begin
        x_d = x_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;

endmodule

// File: rtl/crop_xwindow.sv
// Forwards the fixed-size window [xs, xs+CROP_W) x [Y_START, Y_START+CROP_H)
// of the pixel stream with window-relative coordinates and frame strobes.
module crop_xwindow
  import crop_pkg::*;
#(
  parameter int DW         = 10,
  parameter int H_ACT      = FRAME_W,
  parameter int V_ACT      = FRAME_H,
  parameter int CROP_W     = DEF_CROP_W,
  parameter int Y_START    = 0,
  parameter int CROP_H     = FRAME_H,
  parameter int DEF_XSTART = DEF_XSTART_C
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iDVAL,
  input  logic [DW-1:0] iDATA,
  input  logic [15:0]   iXSTART,
  output logic          oDVAL,
  output logic [DW-1:0] oDATA,
  output logic [15:0]   oX,
  output logic [15:0]   oY,
  output logic          oSOF,
  output logic          oEOF,
  output logic          oCLAMP
);

  localparam coord_t XS_MAX = coord_t'(H_ACT - CROP_W);

  coord_t x_s, y_s;
  logic   frame_end_s;

  frame_pos_counter #(
    .H_ACT (H_ACT),
    .V_ACT (V_ACT)
  ) u_pos (
    .clk_i       (iCLK),
    .rst_i       (iRST),
    .dval_i      (iDVAL),
    .x_o         (x_s),
    .y_o         (y_s),
    .frame_end_o (frame_end_s)
  );

  state_e        state_q, state_d;
  coord_t        xs_q, xs_d;
  logic          clamp_q, clamp_d;
  coord_t        xs_new_s, xs_eff_s, dx_s, dy_s;
  logic          clamp_new_s, in_win_s;
  logic          dval_q, dval_d;
  logic [DW-1:0] data_q, data_d;
  coord_t        ox_q, ox_d, oy_q, oy_d;
  logic          sof_q, sof_d, eof_q, eof_d;

  always_comb begin
    if (iXSTART == 16'd0) begin
      xs_new_s    = coord_t'(DEF_XSTART);
      clamp_new_s = 1'b0;
    end else if (iXSTART > XS_MAX) begin
      xs_new_s    = XS_MAX;
      clamp_new_s = 1'b1;
    end else begin
      xs_new_s    = iXSTART;
      clamp_new_s = 1'b0;
    end

    state_d = state_q;
    xs_d    = xs_q;
    clamp_d = clamp_q;
    case (state_q)
      S_IDLE: begin
        if (iDVAL) begin
          xs_d    = xs_new_s;
          clamp_d = clamp_new_s;
          state_d = frame_end_s ? S_IDLE : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (frame_end_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The first pixel of a frame is judged against the xs latched this cycle.
    // Offsets below the window wrap to large values and fail the range test.
    xs_eff_s = (state_q == S_IDLE) ? xs_new_s : xs_q;
    dx_s     = x_s - xs_eff_s;
    dy_s     = y_s - coord_t'(Y_START);
    in_win_s = (dx_s < coord_t'(CROP_W)) && (dy_s < coord_t'(CROP_H));

    dval_d = iDVAL & in_win_s;
    data_d = data_q;
    ox_d   = ox_q;
    oy_d   = oy_q;
    if (dval_d) begin
      data_d = iDATA;
      ox_d   = dx_s;
      oy_d   = dy_s;
    end else begin
      data_d = data_q;
    end
    sof_d = dval_d & (dx_s == 16'd0) & (dy_s == 16'd0);
    eof_d = dval_d & (dx_s == coord_t'(CROP_W - 1)) & (dy_s == coord_t'(CROP_H - 1));
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_IDLE;
      xs_q    <= coord_t'(DEF_XSTART);
      clamp_q <= 1'b0;
      dval_q  <= 1'b0;
      data_q  <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      clamp_q <= clamp_d;
      dval_q  <= dval_d;
      data_q  <= data_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
    end
  end

  assign oDVAL  = dval_q;
  assign oDATA  = data_q;
  assign oX     = ox_q;
  assign oY     = oy_q;
  assign oSOF   = sof_q;
  assign oEOF   = eof_q;
  assign oCLAMP = clamp_q;

endmodule

// File: tb/tb_crop_xwindow.sv
// Scoreboard bench for crop_xwindow on a reduced 64x12 raster so that
// several complete frames fit in a short run.
module tb_crop_xwindow;
  localparam int DW  = 10;
  localparam int H   = 64;
  localparam int V   = 12;
  localparam int CW  = 32;
  localparam int YS  = 1;
  localparam int CH  = 10;
  localparam int DEF = 16;

  logic          clk = 1'b0;
  logic          iRST, iDVAL;
  logic [DW-1:0] iDATA;
  logic [15:0]   iXSTART;
  logic          oDVAL, oSOF, oEOF, oCLAMP;
  logic [DW-1:0] oDATA;
  logic [15:0]   oX, oY;

  always #5 clk = ~clk;

  crop_xwindow #(
    .DW(DW), .H_ACT(H), .V_ACT(V), .CROP_W(CW),
    .Y_START(YS), .CROP_H(CH), .DEF_XSTART(DEF)
  ) dut (
    .iCLK(clk), .iRST(iRST), .iDVAL(iDVAL), .iDATA(iDATA), .iXSTART(iXSTART),
    .oDVAL(oDVAL), .oDATA(oDATA), .oX(oX), .oY(oY),
    .oSOF(oSOF), .oEOF(oEOF), .oCLAMP(oCLAMP)
  );

  typedef struct packed {
    logic [31:0]   c;
    logic [DW-1:0] d;
    logic [15:0]   x;
    logic [15:0]   y;
    logic          sof;
    logic          eof;
  } beat_t;

  beat_t exp_q[$];
  beat_t e_mon;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    bx = 0, by = 0, xs_m = DEF;
  bit    in_frame = 1'b0, clamp_m = 1'b0;
  int    beats = 0, sofs = 0, eofs = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (oDVAL) begin
      beats++;
      if (oSOF) sofs++;
      if (oEOF) eofs++;
      check_val("beat_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e_mon = exp_q.pop_front();
        check_val("latency", 64'(cyc), 64'(e_mon.c));
        check_val("data", 64'(oDATA), 64'(e_mon.d));
        check_val("ox", 64'(oX), 64'(e_mon.x));
        check_val("oy", 64'(oY), 64'(e_mon.y));
        check_val("sof", 64'(oSOF), 64'(e_mon.sof));
        check_val("eof", 64'(oEOF), 64'(e_mon.eof));
      end
    end else begin
      check_val("idle_strobes", 64'({oSOF, oEOF}), 64'(0));
    end
  end

  task automatic drive(input bit dv, input int xst);
    beat_t b;
    @(posedge clk);
    #1;
    iRST    = 1'b0;
    iDVAL   = dv;
    iDATA   = DW'($urandom);
    iXSTART = 16'(xst);
    if (dv) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        if (xst == 0) begin
          xs_m = DEF; clamp_m = 1'b0;
        end else if (xst > H - CW) begin
          xs_m = H - CW; clamp_m = 1'b1;
        end else begin
          xs_m = xst; clamp_m = 1'b0;
        end
      end
      if (bx >= xs_m && bx < xs_m + CW && by >= YS && by < YS + CH) begin
        b.c   = 32'(cyc + 1);
        b.d   = iDATA;
        b.x   = 16'(bx - xs_m);
        b.y   = 16'(by - YS);
        b.sof = (bx == xs_m) && (by == YS);
        b.eof = (bx == xs_m + CW - 1) && (by == YS + CH - 1);
        exp_q.push_back(b);
      end
      if (bx == H - 1) begin
        bx = 0;
        if (by == V - 1) begin
          by = 0; in_frame = 1'b0;
        end else begin
          by++;
        end
      end else begin
        bx++;
      end
    end
  endtask

  task automatic end_frame_checks(input string tag);
    drive(1'b0, int'(iXSTART));
    drive(1'b0, int'(iXSTART));
    check_val({tag, "_beats"}, 64'(beats), 64'(CW * CH));
    check_val({tag, "_sof_count"}, 64'(sofs), 64'(1));
    check_val({tag, "_eof_count"}, 64'(eofs), 64'(1));
    check_val({tag, "_clamp"}, 64'(oCLAMP), 64'(clamp_m));
    check_val({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
    beats = 0; sofs = 0; eofs = 0;
  endtask

  task automatic run_frame(input string tag, input int xst, input int stall_pct,
                           input int chg_line, input int chg_xst);
    int n = 0;
    int cur = xst;
    bit dv;
    while (n < H * V) begin
      if (by == chg_line) cur = chg_xst;
      dv = ($urandom_range(0, 99) >= stall_pct);
      drive(dv, cur);
      if (dv) n++;
    end
    end_frame_checks(tag);
  endtask

  initial begin
    iRST = 1'b1; iDVAL = 1'b1; iDATA = '0; iXSTART = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_dval", 64'(oDVAL), 64'(0));
    check_val("rst_data", 64'(oDATA), 64'(0));
    check_val("rst_x", 64'(oX), 64'(0));
    check_val("rst_y", 64'(oY), 64'(0));
    check_val("rst_strobes", 64'({oSOF, oEOF}), 64'(0));
    check_val("rst_clamp", 64'(oCLAMP), 64'(0));
    beats = 0; sofs = 0; eofs = 0;

    run_frame("xs20", 20, 0, -1, 0);
    run_frame("default", 0, 0, -1, 0);
    run_frame("clamp", 50, 0, -1, 0);
    run_frame("stall", 10, 30, -1, 0);
    run_frame("chg_n", 10, 0, 6, 30);
    run_frame("chg_n1", 30, 0, -1, 0);
    run_frame("clamp_again", 60, 0, -1, 0);

    // Abort a frame at input (5,6) with a one-cycle reset.
    while (!(bx == 5 && by == 6)) drive(1'b1, 12);
    @(posedge clk);
    #1;
    iRST = 1'b1; iDVAL = 1'b1; iDATA = DW'($urandom);
    bx = 0; by = 0; in_frame = 1'b0;
    drive(1'b0, 25);
    check_val("abort_eof", 64'(eofs), 64'(0));
    check_val("abort_drained", 64'(exp_q.size()), 64'(0));
    check_val("abort_clamp_cleared", 64'(oCLAMP), 64'(0));
    beats = 0; sofs = 0; eofs = 0;
    run_frame("after_abort", 25, 0, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
